sysarr_out_writeback: RTL and testbench

- Consumes the row assembled by the systolic-array output shift FIFO and writes it to the output scratchpad as one DW*N-wide word per row.
- Counts the FIFO's shift strobes to detect a full row, then captures the row and performs a valid/ready write.
- While a row is being captured or written, it asserts stall back to the drain logic so the FIFO is not shifted.
- One tile is N rows; after the last row is written, done pulses.

---
 rtl/sysarr_out_writeback.sv | 131 +++++++++++++
 tb/tb_sysarr_out_writeback.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sysarr_out_writeback.sv
// Systolic-array output writeback: counts FIFO shift strobes, captures each full row
// and writes it to the output scratchpad as one DW*N-bit word per row.
module sysarr_out_writeback #(
    parameter int unsigned DW     = 16,
    parameter int unsigned N      = 4,
    parameter int unsigned ADDR_W = 10
) (
    input  logic              clk,
    input  logic              nRST,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              shift,
    input  logic [DW*N-1:0]   row_in,
    output logic              stall,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DW*N-1:0]   wr_data,
    input  logic              wr_ready,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CntW-1:0] LastIdx = CntW'(N - 1);

    typedef enum logic [2:0] {
        StIdle,
        StCollect,
        StCapture,
        StWrite,
        StDone
    } state_e;

    state_e            state_q;
    logic [CntW-1:0]   elem_cnt_q;
    logic [CntW-1:0]   row_idx_q;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [DW*N-1:0]   wr_data_q;
    logic              wr_en_q;
    logic              done_q;
    logic              err_q;
    logic              handshake;

    // Stall must follow the state directly so the drain logic sees it in the same cycle.
    assign stall     = (state_q == StCapture) || (state_q == StWrite);
    assign busy      = (state_q != StIdle);
    assign handshake = wr_en_q && wr_ready;

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign done    = done_q;
    assign err     = err_q;

    always_ff @(posedge clk or posedge nRST) begin
        if (nRST) begin
            state_q    <= StIdle;
            elem_cnt_q <= '0;
            row_idx_q  <= '0;
            base_q     <= '0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            wr_en_q    <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            // A shift while stalled is dropped; only the sticky flag records it.
            if (shift && stall) begin
                err_q <= 1'b1;
            end

            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        base_q     <= base_addr;
                        elem_cnt_q <= '0;
                        row_idx_q  <= '0;
                        err_q      <= 1'b0;
                        state_q    <= StCollect;
                    end
                end

                StCollect: begin
                    if (shift) begin
                        if (elem_cnt_q == LastIdx) begin
                            elem_cnt_q <= '0;
                            state_q    <= StCapture;
                        end else begin
                            elem_cnt_q <= elem_cnt_q + CntW'(1);
                        end
                    end
                end

                // The FIFO updated on the Nth shift edge, so row_in is complete here.
                StCapture: begin
                    wr_data_q <= row_in;
                    wr_addr_q <= base_q + ADDR_W'(row_idx_q);
                    wr_en_q   <= 1'b1;
                    state_q   <= StWrite;
                end

                StWrite: begin
                    if (handshake) begin
                        wr_en_q <= 1'b0;
                        if (row_idx_q == LastIdx) begin
                            done_q  <= 1'b1;
                            state_q <= StDone;
                        end else begin
                            row_idx_q <= row_idx_q + CntW'(1);
                            state_q   <= StCollect;
                        end
                    end
                end

                StDone: begin
                    done_q  <= 1'b0;
                    state_q <= StIdle;
                end

                default: begin
                    wr_en_q <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sysarr_out_writeback.sv
// Bench for sysarr_out_writeback: drives a model FIFO and checks every row write, timing
// and status flag against expectations derived from the tile rules.
module tb_sysarr_out_writeback;

    localparam int unsigned DW = 16;
    localparam int unsigned N  = 4;
    localparam int unsigned AW = 10;

    logic            clk = 1'b0;
    logic            nRST;
    logic            start;
    logic [AW-1:0]   base_addr;
    logic            shift;
    logic [DW*N-1:0] row_in;
    logic            stall;
    logic            wr_en;
    logic [AW-1:0]   wr_addr;
    logic [DW*N-1:0] wr_data;
    logic            wr_ready;
    logic            busy;
    logic            done;
    logic            err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sysarr_out_writeback #(
        .DW    (DW),
        .N     (N),
        .ADDR_W(AW)
    ) dut (
        .clk      (clk),
        .nRST     (nRST),
        .start    (start),
        .base_addr(base_addr),
        .shift    (shift),
        .row_in   (row_in),
        .stall    (stall),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_ready (wr_ready),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    // One shift strobe; the model FIFO shifts on the same edge, newest element lowest.
    task automatic push(input logic [DW-1:0] e);
        shift = 1'b1;
        adv();
        shift = 1'b0;
        row_in = {row_in[DW*(N-1)-1:0], e};
    endtask

    task automatic test_reset();
        nRST = 1'b1; start = 1'b0; base_addr = '0; shift = 1'b0; wr_ready = 1'b1;
        row_in = '0;
        #1;
        checks++;
        if ({stall, wr_en, busy, done, err} !== 5'b0 || wr_addr !== '0 || wr_data !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got flags %b addr %h data %h, expected all zero",
                     {stall, wr_en, busy, done, err}, wr_addr, wr_data);
        end
        adv(); adv();
        nRST = 1'b0;
        // Shifts in IDLE must be neither counted nor flagged.
        for (int i = 0; i < 3; i++) push(DW'($urandom));
        adv();
        checks++;
        if ({stall, wr_en, busy, done, err} !== 5'b0) begin
            errors++;
            $display("FAIL idle_shift_ignored: got flags %b expected 00000",
                     {stall, wr_en, busy, done, err});
        end
    endtask

    // Runs one tile. hold_row/hold_n: WRITE cycles with wr_ready low on that row.
    // err_row: inject a shift during the held WRITE. abort_row: assert reset in that WRITE.
    task automatic run_tile(input logic [AW-1:0] base, input int gap, input int hold_row,
                            input int hold_n, input int err_row, input int abort_row,
                            input bit seq_data, input bit glitch_start);
        logic [DW*N-1:0] exp_data;
        logic [AW-1:0]   exp_addr;
        bit              exp_err;
        exp_err   = 1'b0;
        base_addr = base;
        start     = 1'b1;
        adv();
        start     = 1'b0;
        base_addr = ~base;
        checks++;
        if (busy !== 1'b1 || err !== 1'b0) begin
            errors++;
            $display("FAIL start_accept: got busy %b err %b expected busy 1 err 0", busy, err);
        end
        for (int r = 0; r < int'(N); r++) begin
            for (int e = 0; e < int'(N); e++) begin
                for (int g = 0; g < gap; g++) begin
                    adv();
                    checks++;
                    if ({stall, wr_en, done} !== 3'b000) begin
                        errors++;
                        $display("FAIL gap_idle: row %0d elem %0d got stall/wr_en/done %b exp 000",
                                 r, e, {stall, wr_en, done});
                    end
                end
                if (glitch_start && r == 1 && e == 0) start = 1'b1;
                push(seq_data ? DW'(r * int'(N) + e + 1) : DW'($urandom));
                start = 1'b0;
                if (e < int'(N) - 1) begin
                    checks++;
                    if ({stall, wr_en, done} !== 3'b000) begin
                        errors++;
                        $display("FAIL collect: row %0d elem %0d got stall/wr_en/done %b exp 000",
                                 r, e, {stall, wr_en, done});
                    end
                end
            end
            // First cycle after the Nth shift: capture, stalled, no request yet.
            checks++;
            if ({stall, wr_en, busy} !== 3'b101) begin
                errors++;
                $display("FAIL capture: row %0d got stall/wr_en/busy %b exp 101",
                         r, {stall, wr_en, busy});
            end
            exp_data = row_in;
            exp_addr = AW'((int'(base) + r) % (1 << AW));
            wr_ready = (r == hold_row) ? 1'b0 : 1'b1;
            adv();
            checks++;
            if (wr_en !== 1'b1 || stall !== 1'b1 || wr_addr !== exp_addr ||
                wr_data !== exp_data) begin
                errors++;
                $display("FAIL write_req: row %0d got en %b stall %b addr %h data %h exp 1 1 %h %h",
                         r, wr_en, stall, wr_addr, wr_data, exp_addr, exp_data);
            end
            if (r == abort_row) begin
                #2 nRST = 1'b1;
                #1;
                checks++;
                if ({stall, wr_en, busy, done, err} !== 5'b0 || wr_addr !== '0 ||
                    wr_data !== '0) begin
                    errors++;
                    $display("FAIL async_abort: got flags %b addr %h data %h expected all zero",
                             {stall, wr_en, busy, done, err}, wr_addr, wr_data);
                end
                return;
            end
            if (r == hold_row) begin
                for (int c = 1; c <= hold_n; c++) begin
                    if (r == err_row && c == 1) begin
                        push(DW'($urandom));
                        exp_err = 1'b1;
                    end else begin
                        adv();
                    end
                    checks++;
                    if (wr_en !== 1'b1 || stall !== 1'b1 || wr_addr !== exp_addr ||
                        wr_data !== exp_data || err !== exp_err) begin
                        errors++;
                        $display("FAIL write_hold: row %0d cyc %0d got en %b stall %b err %b addr %h data %h exp err %b addr %h data %h",
                                 r, c, wr_en, stall, err, wr_addr, wr_data, exp_err,
                                 exp_addr, exp_data);
                    end
                end
                wr_ready = 1'b1;
            end
            adv();
            checks++;
            if (wr_en !== 1'b0 || stall !== 1'b0 || err !== exp_err) begin
                errors++;
                $display("FAIL post_handshake: row %0d got en %b stall %b err %b exp 0 0 %b",
                         r, wr_en, stall, err, exp_err);
            end
            checks++;
            if (r == int'(N) - 1) begin
                if (done !== 1'b1 || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL done_pulse: got done %b busy %b exp 1 1", done, busy);
                end
            end else if (done !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL row_continue: row %0d got done %b busy %b exp 0 1", r, done, busy);
            end
        end
        adv();
        checks++;
        if ({done, busy, stall, wr_en} !== 4'b0 || err !== exp_err) begin
            errors++;
            $display("FAIL tile_end: got done/busy/stall/wr_en %b err %b exp 0000 err %b",
                     {done, busy, stall, wr_en}, err, exp_err);
        end
    endtask

    task automatic test_basic();
        run_tile(10'h010, 0, -1, 0, -1, -1, 1'b1, 1'b0);
    endtask

    task automatic test_backpressure();
        run_tile(AW'($urandom), 0, 1, 5, -1, -1, 1'b0, 1'b0);
    endtask

    task automatic test_gapped();
        run_tile(AW'($urandom), 2, -1, 0, -1, -1, 1'b0, 1'b1);
    endtask

    task automatic test_err_sticky();
        run_tile(AW'($urandom), 0, 2, 3, 2, -1, 1'b0, 1'b0);
        // The next tile's start clears err; run_tile checks err==0 right after start.
        run_tile(AW'($urandom), 1, -1, 0, -1, -1, 1'b0, 1'b0);
    endtask

    task automatic test_wrap();
        run_tile(10'h3FF, 0, -1, 0, -1, -1, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid();
        run_tile(AW'($urandom), 0, 2, 3, -1, 2, 1'b0, 1'b0);
        adv();
        nRST = 1'b0;
        adv();
        checks++;
        if ({busy, done, wr_en, err} !== 4'b0) begin
            errors++;
            $display("FAIL after_reset: got busy/done/wr_en/err %b exp 0000",
                     {busy, done, wr_en, err});
        end
        run_tile(AW'($urandom), 0, -1, 0, -1, -1, 1'b0, 1'b1);
    endtask

    task automatic test_back_to_back();
        for (int t = 0; t < 2; t++) begin
            run_tile(AW'($urandom), int'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                     int'($urandom_range(1, 3)), -1, -1, 1'b0, 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_gapped();
        test_err_sticky();
        test_wrap();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
